// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default activation width, kernel size,
// the signed activation type and the window-generator FSM state encoding.
package cnn_pkg;

  localparam int CNN_DATA_W = 8;
  localparam int CNN_K      = 3;

  typedef logic signed [CNN_DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. Read and write share the column address;
// the read returns the value from the previous row before this cycle's write.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Combinational read so the old row value is usable in the handshake cycle.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream; hands each complete
// window to a convolution engine with a start/conv_done handshake.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = CNN_K,
  parameter int IN_CH  = 1,
  parameter int DATA_W = CNN_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic signed [DATA_W-1:0]  pix_data [0:IN_CH-1],
  output logic                      pix_ready,
  output logic signed [DATA_W-1:0]  window [0:K*K*IN_CH-1],
  output logic                      start,
  input  logic                      conv_done,
  output logic [$clog2(IMG_H)-1:0]  out_row,
  output logic [$clog2(IMG_W)-1:0]  out_col,
  output logic                      frame_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int PIX_W = IN_CH * DATA_W;

  win_state_t state;
  win_state_t state_next;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             hs;
  logic             win_complete;
  logic             last_win;

  logic [PIX_W-1:0]         pix_flat;
  logic [PIX_W-1:0]         lb_rd   [0:K-2];
  logic [PIX_W-1:0]         lb_wr   [0:K-2];
  logic [PIX_W-1:0]         col_new [0:K-1];
  logic signed [DATA_W-1:0] win_q   [0:K-1][0:K-1][0:IN_CH-1];

  assign hs           = (state == ST_ACCEPT) && pix_valid;
  assign win_complete = (row >= ROW_W'(K-1)) && (col >= COL_W'(K-1));
  assign last_win     = (out_row == ROW_W'(IMG_H-K)) && (out_col == COL_W'(IMG_W-K));

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < IN_CH; gi++) begin : g_flat
      assign pix_flat[gi*DATA_W +: DATA_W] = pix_data[gi];
    end

    // Buffer 0 holds the row above; each further buffer is fed by the one before.
    for (gi = 0; gi < K-1; gi++) begin : g_lb
      if (gi == 0) begin : g_first
        assign lb_wr[gi] = pix_flat;
      end else begin : g_chain
        assign lb_wr[gi] = lb_rd[gi-1];
      end
      line_buffer #(
        .DEPTH(IMG_W),
        .WIDTH(PIX_W)
      ) u_lb (
        .clk    (clk),
        .addr   (col),
        .wr_en  (hs),
        .wr_data(lb_wr[gi]),
        .rd_data(lb_rd[gi])
      );
    end

    // New right column: bottom row is the live pixel, older rows come from the buffers.
    assign col_new[K-1] = pix_flat;
    for (gi = 0; gi < K-1; gi++) begin : g_col
      assign col_new[gi] = lb_rd[K-2-gi];
    end

    for (gi = 0; gi < K; gi++) begin : g_win_r
      for (gj = 0; gj < K; gj++) begin : g_win_c
        for (gk = 0; gk < IN_CH; gk++) begin : g_win_ch
          assign window[(gi*K+gj)*IN_CH+gk] = win_q[gi][gj][gk];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          for (int ch = 0; ch < IN_CH; ch++) begin
            win_q[r][c][ch] <= '0;
          end
        end
      end
    end else if (hs) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          for (int ch = 0; ch < IN_CH; ch++) begin
            win_q[r][c][ch] <= win_q[r][c+1][ch];
          end
        end
        for (int ch = 0; ch < IN_CH; ch++) begin
          win_q[r][K-1][ch] <= col_new[r][ch*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (hs) begin
      if (col == COL_W'(IMG_W-1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H-1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Output coordinates are captured with the window so they stay frozen through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (hs && win_complete) begin
        out_row <= row - ROW_W'(K-1);
        out_col <= col - COL_W'(K-1);
      end
      frame_done <= (state == ST_WAIT) && conv_done && last_win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    start      = 1'b0;
    unique case (state)
      ST_ACCEPT: begin
        pix_ready = 1'b1;
        if (pix_valid && win_complete) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start      = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
          state_next = ST_ACCEPT;
        end
      end
      default: state_next = ST_ACCEPT;
    endcase
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x5 image with a 3x3 kernel and a
// modelled convolution engine answering each start after a set delay.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int KK    = 3;
  localparam int IN_CH = 1;
  localparam int DW    = 8;
  localparam int NW    = KK*KK*IN_CH;

  typedef struct packed {
    logic [7:0]      base;
    logic [2:0]      orow;
    logic [2:0]      ocol;
    logic            last;
    logic [8:0][7:0] win;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_valid = 1'b0;
  logic signed [DW-1:0] pix_data [0:IN_CH-1];
  logic pix_ready;
  logic signed [DW-1:0] window [0:NW-1];
  logic start;
  logic conv_done;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic frame_done;

  logic done_resp = 1'b0;
  logic done_spur = 1'b0;
  assign conv_done = done_resp | done_spur;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int conv_delay = 2;
  bit spur_issue = 0;
  bit abort_resp = 0;
  bit resp_busy = 0;

  vec_t vecs [0:17];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  conv_window_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (KK),
    .IN_CH (IN_CH),
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .window    (window),
    .start     (start),
    .conv_done (conv_done),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: validates each issued window, checks stability during WAIT, then answers.
  initial begin : responder
    vec_t e;
    int d;
    int mism;
    logic signed [DW-1:0] snap [0:NW-1];
    forever begin
      @(negedge clk);
      if (start && !rst) begin
        resp_busy = 1;
        start_cnt++;
        if (exp_q.size() == 0) begin
          e = '0;
          check("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < NW; i++) begin
            check($sformatf("win(%0d,%0d)[%0d]", e.orow, e.ocol, i), int'(window[i]), int'(e.win[i]));
          end
          check("out_row", int'(out_row), int'(e.orow));
          check("out_col", int'(out_col), int'(e.ocol));
          $display("window (%0d,%0d) base %0d issued", e.orow, e.ocol, e.base);
        end
        check("pix_ready_in_issue", int'(pix_ready), 0);
        for (int i = 0; i < NW; i++) snap[i] = window[i];
        if (spur_issue) done_resp = 1;
        d = 0;
        while (d < conv_delay && !abort_resp) begin
          @(negedge clk);
          done_resp = 0;
          if (!abort_resp) begin
            mism = 0;
            for (int i = 0; i < NW; i++) if (window[i] != snap[i]) mism++;
            check("window_stable_wait", mism, 0);
            check("pix_ready_in_wait", int'(pix_ready), 0);
            check("start_one_cycle", int'(start), 0);
            check("frame_done_in_wait", int'(frame_done), 0);
          end
          d++;
        end
        if (!abort_resp) begin
          done_resp = 1;
          @(negedge clk);
          done_resp = 0;
          check("pix_ready_after_done", int'(pix_ready), 1);
          check("frame_done_after_done", int'(frame_done), int'(e.last));
        end
        resp_busy = 0;
      end
    end
  end

  task automatic send_pixels(input int base, input int npix, input int spur_a, input int spur_b);
    int waited;
    for (int p = 0; p < npix; p++) begin
      @(negedge clk);
      done_spur = 0;
      pix_valid = 1;
      pix_data[0] = DW'(base + p);
      waited = 0;
      while (!pix_ready && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!pix_ready) begin
        check("pix_ready_timeout", 0, 1);
        return;
      end
      if (p == spur_a || p == spur_b) done_spur = 1;
      @(posedge clk);
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    done_spur = 0;
    pix_valid = 0;
    while ((exp_q.size() != 0 || resp_busy || !pix_ready) && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check("idle_reached", int'(exp_q.size() == 0 && !resp_busy && pix_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < NW; i++) if (window[i] != 0) nz++;
    check({tag, "_window_zero"}, nz, 0);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_out_row"}, int'(out_row), 0);
    check({tag, "_out_col"}, int'(out_col), 0);
  endtask

  task automatic push_frame(input int first);
    for (int i = 0; i < 9; i++) exp_q.push_back(vecs[first+i]);
  endtask

  initial begin : main
    int s0;
    int waited;
    vec_t v;

    // Expected windows: pixel = base + row*5 + col, windows in raster order.
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 9; w++) begin
        v = '0;
        v.base = (f == 0) ? 8'd0 : 8'd100;
        v.orow = 3'(w / 3);
        v.ocol = 3'(w % 3);
        v.last = (w == 8);
        for (int r = 0; r < KK; r++)
          for (int c = 0; c < KK; c++)
            v.win[r*KK+c] = 8'(int'(v.base) + (int'(v.orow) + r) * IMG_W + int'(v.ocol) + c);
        vecs[f*9+w] = v;
      end
    end

    pix_data[0] = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    check("reset_pix_ready", int'(pix_ready), 1);

    // Single frame, engine answers 2 cycles after start.
    push_frame(0);
    conv_delay = 2;
    s0 = start_cnt;
    send_pixels(0, 25, -1, -1);
    wait_idle();
    check("frame1_starts", start_cnt - s0, 9);
    $display("frame 1 done: %0d starts", start_cnt - s0);

    // Slow engine with valid held high, then a back-to-back frame with offset 100.
    push_frame(0);
    push_frame(9);
    conv_delay = 7;
    s0 = start_cnt;
    send_pixels(0, 25, -1, -1);
    send_pixels(100, 25, -1, -1);
    wait_idle();
    check("frames23_starts", start_cnt - s0, 18);
    $display("frames 2-3 done: %0d starts", start_cnt - s0);

    // Spurious conv_done in ACCEPT (mid-frame) and in every ISSUE cycle.
    push_frame(0);
    conv_delay = 2;
    spur_issue = 1;
    s0 = start_cnt;
    send_pixels(0, 25, 5, 15);
    wait_idle();
    spur_issue = 0;
    check("frame4_starts", start_cnt - s0, 9);
    done_spur = 1;
    @(negedge clk);
    done_spur = 0;
    check("spur_after_frame_frame_done", int'(frame_done), 0);
    check("spur_after_frame_pix_ready", int'(pix_ready), 1);
    repeat (3) @(negedge clk);
    check("spur_after_frame_no_start", start_cnt - s0, 9);
    $display("frame 4 (spurious done) finished: %0d starts", start_cnt - s0);

    // Reset during WAIT of the 4th window.
    push_frame(0);
    conv_delay = 20;
    s0 = start_cnt;
    send_pixels(0, 18, -1, -1);
    @(negedge clk);
    pix_valid = 0;
    waited = 0;
    while (start_cnt - s0 < 4 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("fourth_start_seen", start_cnt - s0, 4);
    repeat (2) @(negedge clk);
    abort_resp = 1;
    rst = 1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_pix_ready", int'(pix_ready), 1);
    check("midrst_resp_idle", int'(resp_busy), 0);
    abort_resp = 0;
    $display("reset applied during WAIT of window 4");

    // The frame after reset must match the first frame exactly.
    push_frame(0);
    conv_delay = 2;
    s0 = start_cnt;
    send_pixels(0, 25, -1, -1);
    wait_idle();
    check("frame_after_rst_starts", start_cnt - s0, 9);
    $display("post-reset frame done: %0d starts", start_cnt - s0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
